// File: rtl/uriscv_irq_ctrl.sv
// External interrupt controller: latches level/edge sources, arbitrates by fixed
// priority and exposes a claim/complete register handshake to the trap handler.
module uriscv_irq_ctrl #(
    parameter int unsigned NUM_IRQ       = 8,
    parameter logic [31:0] BASE_VECTOR   = 32'h0000_0100,
    parameter logic [31:0] VECTOR_STRIDE = 32'd4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               req_i,
    input  logic               wr_i,
    input  logic [7:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               ack_o,
    output logic               intr_o,
    output logic [31:0]        isr_vector_o
);

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] enable;
    logic [NUM_IRQ-1:0] edge_mode;
    logic [NUM_IRQ-1:0] prev;

    logic [NUM_IRQ-1:0] cand;
    logic               win_valid;
    logic [4:0]         win_idx;

    logic [5:0]         word;
    logic               rd_req;
    logic               wr_req;
    logic               claim_rd;
    logic               complete_wr;
    logic               swset_wr;

    logic [NUM_IRQ-1:0] claim_oh;
    logic [NUM_IRQ-1:0] complete_oh;
    logic [NUM_IRQ-1:0] active_n;
    logic [NUM_IRQ-1:0] set_level;
    logic [NUM_IRQ-1:0] set_edge;
    logic [NUM_IRQ-1:0] set_sw;
    logic [NUM_IRQ-1:0] pending_n;
    logic [31:0]        rd_val;

    logic               unused_bits;

    assign unused_bits = ^{addr_i[1:0], wdata_i};

    assign word        = addr_i[7:2];
    assign rd_req      = req_i & ~wr_i;
    assign wr_req      = req_i & wr_i;
    assign claim_rd    = rd_req & (word == 6'd3);
    assign complete_wr = wr_req & (word == 6'd3);
    assign swset_wr    = wr_req & (word == 6'd5);

    assign cand = pending & enable;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (!win_valid && cand[i]) begin
                win_valid = 1'b1;
                win_idx   = 5'(i);
            end
        end
    end

    always_comb begin
        claim_oh    = '0;
        complete_oh = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            claim_oh[i]    = claim_rd & win_valid & (win_idx == 5'(i));
            complete_oh[i] = complete_wr & active[i] & (wdata_i == 32'(i) + 32'd1);
        end
    end

    assign active_n = (active | claim_oh) & ~complete_oh;

    // Level sources are gated by the post-edge active state, so a claim retires a
    // held line immediately and a complete re-pends it on the same edge.
    assign set_level = irq_i & ~edge_mode & ~active_n;
    assign set_edge  = irq_i & ~prev & edge_mode;
    assign set_sw    = swset_wr ? wdata_i[NUM_IRQ-1:0] : '0;
    assign pending_n = (pending & ~claim_oh) | set_level | set_edge | set_sw;

    always_comb begin
        rd_val = '0;
        case (word)
            6'd0:    rd_val = 32'(pending);
            6'd1:    rd_val = 32'(enable);
            6'd2:    rd_val = 32'(edge_mode);
            6'd3:    rd_val = win_valid ? (32'(win_idx) + 32'd1) : '0;
            6'd4:    rd_val = 32'(active);
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending      <= '0;
            active       <= '0;
            enable       <= '0;
            edge_mode    <= '0;
            prev         <= '0;
            intr_o       <= 1'b0;
            isr_vector_o <= BASE_VECTOR;
            ack_o        <= 1'b0;
            rdata_o      <= '0;
        end else begin
            pending <= pending_n;
            active  <= active_n;
            prev    <= irq_i;
            if (wr_req && word == 6'd1) enable    <= wdata_i[NUM_IRQ-1:0];
            if (wr_req && word == 6'd2) edge_mode <= wdata_i[NUM_IRQ-1:0];
            intr_o       <= |cand;
            isr_vector_o <= win_valid ? (BASE_VECTOR + 32'(win_idx) * VECTOR_STRIDE)
                                      : BASE_VECTOR;
            ack_o        <= req_i;
            rdata_o      <= rd_req ? rd_val : '0;
        end
    end

endmodule
